// File: rtl/mm_result_reducer.sv
// Sums every GROUP consecutive products into one tagged result and buffers the results in a small FIFO.
// Optional feature: define SAT_EN to clamp stored sums to 2^IN_W-1 and flag the clamped entries.
module mm_result_reducer #(
    parameter int IN_W       = 8,
    parameter int GROUP      = 4,
    parameter int SUM_W      = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk1,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_clr,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [SUM_W-1:0] out_sum,
    output logic [7:0]       out_idx,
    output logic             out_sat,
    output logic             overflow
);

    localparam int CW = $clog2(GROUP);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {
        IDLE,
        ACC
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [SUM_W-1:0] acc_q, acc_d;
    logic [7:0]       idx_q, idx_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic [SUM_W-1:0] out_sum_q, out_sum_d;
    logic [7:0]       out_idx_q, out_idx_d;
    logic             overflow_q, overflow_d;

    logic [SUM_W-1:0] sum_mem [FIFO_DEPTH];
    logic [7:0]       idx_mem [FIFO_DEPTH];

    logic [SUM_W-1:0] sum_full;
    logic [SUM_W-1:0] store_sum;
    logic             group_done;
    logic             full;
    logic             pop;
    logic             push_ok;
    logic [AW:0]      remain;

`ifdef SAT_EN
    localparam logic [SUM_W-1:0] SAT_MAX = SUM_W'((1 << IN_W) - 1);
    logic store_sat;
    logic out_sat_q, out_sat_d;
    logic sat_mem [FIFO_DEPTH];
`endif

    assign sum_full = acc_q + SUM_W'(in_data);

`ifdef SAT_EN
    assign store_sat = (sum_full > SAT_MAX);
    assign store_sum = store_sat ? SAT_MAX : sum_full;
`else
    assign store_sum = sum_full;
`endif

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        group_done = 1'b0;
        if (in_clr) begin
            state_d = IDLE;
            cnt_d   = '0;
            acc_d   = '0;
        end else if (in_valid) begin
            case (state_q)
                IDLE: begin
                    state_d = ACC;
                    cnt_d   = CW'(1);
                    acc_d   = sum_full;
                end
                ACC: begin
                    if (cnt_q == CW'(GROUP - 1)) begin
                        group_done = 1'b1;
                        state_d    = IDLE;
                        cnt_d      = '0;
                        acc_d      = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                        acc_d = sum_full;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    acc_d   = '0;
                end
            endcase
        end
    end

    // A pop frees a slot in the same cycle, so a full FIFO can still accept a push alongside it.
    always_comb begin
        full       = (count_q == (AW + 1)'(FIFO_DEPTH));
        pop        = (count_q != '0) && out_ready && !in_clr;
        push_ok    = group_done && (!full || pop);
        overflow_d = group_done && !push_ok;
        remain     = count_q - (AW + 1)'(pop);

        idx_d    = idx_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (in_clr) begin
            idx_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (group_done) idx_d = idx_q + 8'd1;
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = remain + (AW + 1)'(push_ok);
        end
        out_valid_d = (count_d != '0);

        out_sum_d = out_sum_q;
        out_idx_d = out_idx_q;
`ifdef SAT_EN
        out_sat_d = out_sat_q;
`endif
        if (!in_clr) begin
            if (remain != '0) begin
                out_sum_d = sum_mem[rd_ptr_d];
                out_idx_d = idx_mem[rd_ptr_d];
`ifdef SAT_EN
                out_sat_d = sat_mem[rd_ptr_d];
`endif
            end else if (push_ok) begin
                out_sum_d = store_sum;
                out_idx_d = idx_q;
`ifdef SAT_EN
                out_sat_d = store_sat;
`endif
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_idx_q   <= '0;
            overflow_q  <= 1'b0;
`ifdef SAT_EN
            out_sat_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_idx_q   <= out_idx_d;
            overflow_q  <= overflow_d;
`ifdef SAT_EN
            out_sat_q   <= out_sat_d;
`endif
        end
    end

    // NOTE: the storage array has no reset; the pointers and count alone decide which entries are live.
    always_ff @(posedge clk1) begin
        if (push_ok) begin
            sum_mem[wr_ptr_q] <= store_sum;
            idx_mem[wr_ptr_q] <= idx_q;
`ifdef SAT_EN
            sat_mem[wr_ptr_q] <= store_sat;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_idx   = out_idx_q;
    assign overflow  = overflow_q;
`ifdef SAT_EN
    assign out_sat   = out_sat_q;
`else
    assign out_sat   = 1'b0;
`endif

endmodule

// File: tb/tb_mm_result_reducer.sv
// Self-checking bench for mm_result_reducer: directed scenarios plus randomized traffic against a queue-based model.
module tb_mm_result_reducer;

    localparam int GROUP = 4;
    localparam int DEPTH = 4;

    logic       clk1 = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_clr = 1'b0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [9:0] out_sum;
    logic [7:0] out_idx;
    logic       out_sat;
    logic       overflow;

    int total = 0;
    int bad = 0;

    mm_result_reducer dut (
        .clk1     (clk1),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_clr   (in_clr),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_sum  (out_sum),
        .out_idx  (out_idx),
        .out_sat  (out_sat),
        .overflow (overflow)
    );

    always #5 clk1 = ~clk1;

    // Reference model: the products of the open group, the queue of stored results, and the visible head.
    typedef struct {
        int sum;
        int idx;
        bit sat;
    } ent_t;

    int   parts[$];
    ent_t q[$];
    int   m_idx_cnt;
    int   m_sum;
    int   m_idx;
    bit   m_sat;
    bit   m_ovf;

    task automatic model_reset();
        parts.delete();
        q.delete();
        m_idx_cnt = 0;
        m_sum = 0;
        m_idx = 0;
        m_sat = 0;
        m_ovf = 0;
    endtask

    task automatic model_step(input bit v, input int d, input bit c, input bit r);
        ent_t e;
        int   s;
        m_ovf = 0;
        if (c) begin
            parts.delete();
            q.delete();
            m_idx_cnt = 0;
        end else begin
            if (q.size() > 0 && r) q.delete(0);
            if (v) begin
                parts.push_back(d);
                if (parts.size() == GROUP) begin
                    s = 0;
                    foreach (parts[i]) s += parts[i];
`ifdef SAT_EN
                    e.sat = (s > 255);
                    e.sum = e.sat ? 255 : s;
`else
                    e.sat = 0;
                    e.sum = s;
`endif
                    e.idx = m_idx_cnt;
                    if (q.size() < DEPTH) q.push_back(e);
                    else m_ovf = 1;
                    m_idx_cnt = (m_idx_cnt + 1) % 256;
                    parts.delete();
                end
            end
        end
        if (q.size() > 0) begin
            m_sum = q[0].sum;
            m_idx = q[0].idx;
            m_sat = q[0].sat;
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge, return at the following falling edge.
    task automatic tick(input bit v, input int d, input bit c, input bit r);
        in_valid  = v;
        in_data   = 8'(d);
        in_clr    = c;
        out_ready = r;
        @(posedge clk1);
        model_step(v, d, c, r);
        @(negedge clk1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        total++; if (out_sum !== 10'd0) begin bad++; $display("FAIL reset_sum: got %0d want 0", out_sum); end
        total++; if (out_idx !== 8'd0) begin bad++; $display("FAIL reset_idx: got %0d want 0", out_idx); end
        total++; if (out_sat !== 1'b0) begin bad++; $display("FAIL reset_sat: got %b want 0", out_sat); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        @(negedge clk1);
        @(negedge clk1);
        rst_n = 1'b1;
        @(negedge clk1);
    endtask

    task automatic test_basic();
        tick(1, 10, 0, 1);
        tick(1, 20, 0, 1);
        tick(1, 30, 0, 1);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early: got %b want 0", out_valid); end
        tick(1, 40, 0, 1);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b want 1", out_valid); end
        total++; if (out_sum !== 10'd100) begin bad++; $display("FAIL basic_sum: got %0d want 100", out_sum); end
        total++; if (out_idx !== 8'd0) begin bad++; $display("FAIL basic_idx: got %0d want 0", out_idx); end
        tick(0, 0, 0, 1);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_popped: got %b want 0", out_valid); end
        total++; if (out_sum !== 10'd100) begin bad++; $display("FAIL basic_hold: got %0d want 100", out_sum); end
    endtask

    task automatic test_sat();
        for (int i = 0; i < 4; i++) tick(1, 255, 0, 1);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL sat_valid: got %b want 1", out_valid); end
        total++; if (out_idx !== 8'd1) begin bad++; $display("FAIL sat_idx: got %0d want 1", out_idx); end
`ifdef SAT_EN
        total++; if (out_sum !== 10'd255) begin bad++; $display("FAIL sat_sum: got %0d want 255", out_sum); end
        total++; if (out_sat !== 1'b1) begin bad++; $display("FAIL sat_flag: got %b want 1", out_sat); end
`else
        total++; if (out_sum !== 10'd1020) begin bad++; $display("FAIL sat_sum: got %0d want 1020", out_sum); end
        total++; if (out_sat !== 1'b0) begin bad++; $display("FAIL sat_flag: got %b want 0", out_sat); end
`endif
        tick(0, 0, 0, 1);
    endtask

    task automatic test_overflow();
        int pulses = 0;
        tick(0, 0, 1, 0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ovf_clr_valid: got %b want 0", out_valid); end
        for (int g = 0; g < 5; g++) begin
            for (int k = 0; k < 4; k++) begin
                tick(1, 1, 0, 0);
                if (overflow === 1'b1) pulses++;
            end
            if (g == 4) begin
                total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_pulse: got %b want 1", overflow); end
            end
        end
        tick(0, 0, 0, 0);
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_one_cycle: got %b want 0", overflow); end
        total++; if (pulses != 1) begin bad++; $display("FAIL ovf_count: got %0d want 1", pulses); end
        total++; if (out_sum !== 10'd4) begin bad++; $display("FAIL ovf_head_sum: got %0d want 4", out_sum); end
        for (int k = 0; k < 4; k++) begin
            total++; if (out_valid !== 1'b1 || out_idx !== 8'(k)) begin
                bad++; $display("FAIL ovf_drain: got valid=%b idx=%0d want valid=1 idx=%0d", out_valid, out_idx, k);
            end
            tick(0, 0, 0, 1);
        end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty: got %b want 0", out_valid); end
        for (int k = 0; k < 4; k++) tick(1, 1, 0, 0);
        total++; if (out_idx !== 8'd5 || out_valid !== 1'b1) begin
            bad++; $display("FAIL ovf_next_idx: got valid=%b idx=%0d want valid=1 idx=5", out_valid, out_idx);
        end
        tick(0, 0, 0, 1);
    endtask

    task automatic test_full_pop();
        tick(0, 0, 1, 0);
        for (int k = 0; k < 19; k++) tick(1, 2, 0, 0);
        tick(1, 2, 0, 1);
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fullpop_ovf: got %b want 0", overflow); end
        for (int k = 1; k < 5; k++) begin
            total++; if (out_valid !== 1'b1 || out_idx !== 8'(k) || out_sum !== 10'd8) begin
                bad++; $display("FAIL fullpop_drain: got valid=%b idx=%0d sum=%0d want 1/%0d/8", out_valid, out_idx, out_sum, k);
            end
            tick(0, 0, 0, 1);
        end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fullpop_empty: got %b want 0", out_valid); end
    endtask

    task automatic test_clr_mid();
        tick(0, 0, 1, 1);
        tick(1, 7, 0, 1);
        tick(1, 9, 0, 1);
        tick(1, 99, 1, 1);
        for (int k = 0; k < 4; k++) tick(1, 5, 0, 1);
        total++; if (out_valid !== 1'b1 || out_sum !== 10'd20 || out_idx !== 8'd0) begin
            bad++; $display("FAIL clr_mid: got valid=%b sum=%0d idx=%0d want 1/20/0", out_valid, out_sum, out_idx);
        end
        tick(0, 0, 0, 1);
    endtask

    task automatic test_reset_mid();
        tick(0, 0, 1, 0);
        for (int k = 0; k < 10; k++) tick(1, 3, 0, 0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rstmid_pre: got %b want 1", out_valid); end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        total++; if (out_valid !== 1'b0 || out_sum !== 10'd0 || out_idx !== 8'd0 || out_sat !== 1'b0 || overflow !== 1'b0) begin
            bad++; $display("FAIL rstmid_outs: got valid=%b sum=%0d idx=%0d sat=%b ovf=%b want all 0", out_valid, out_sum, out_idx, out_sat, overflow);
        end
        @(negedge clk1);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) tick(1, 6, 0, 1);
        total++; if (out_valid !== 1'b1 || out_sum !== 10'd24 || out_idx !== 8'd0) begin
            bad++; $display("FAIL rstmid_next: got valid=%b sum=%0d idx=%0d want 1/24/0", out_valid, out_sum, out_idx);
        end
        tick(0, 0, 0, 1);
    endtask

    task automatic test_random();
        bit v, c, r;
        int d;
        for (int n = 0; n < 1500; n++) begin
            v = ($urandom_range(0, 9) < 7);
            c = ($urandom_range(0, 79) == 0);
            r = ($urandom_range(0, 9) < 4);
            d = ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 255));
            tick(v, d, c, r);
            total++;
            if (out_valid !== (q.size() > 0) || overflow !== m_ovf || out_sum !== 10'(m_sum)
                || out_idx !== 8'(m_idx) || out_sat !== m_sat) begin
                bad++;
                $display("FAIL random@%0d: got v=%b o=%b s=%0d i=%0d t=%b want v=%0d o=%0d s=%0d i=%0d t=%0d", n,
                         out_valid, overflow, out_sum, out_idx, out_sat, q.size() > 0, m_ovf, m_sum, m_idx, m_sat);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_sat();
        test_overflow();
        test_full_pop();
        test_clr_mid();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
